// File: rtl/mux_comm_pkg.sv
// Shared opcodes, FSM state encoding and sizing helper for the mux_comm
// serial-controlled pin crossbar.
package mux_comm_pkg;

   localparam logic [3:0] OP_READ_MAP    = 4'h1;
   localparam logic [3:0] OP_WRITE_MAP   = 4'h2;
   localparam logic [3:0] OP_READ_MASK   = 4'h3;
   localparam logic [3:0] OP_WRITE_MASK  = 4'h4;
   localparam logic [3:0] OP_READ_INPUTS = 4'h5;
   localparam logic [3:0] OP_CLEAR_ERR   = 4'h6;

   localparam logic [7:0] REPLY_OK  = 8'h00;
   localparam logic [7:0] REPLY_ERR = 8'hEE;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_RX_PAYLOAD = 2'd1,
      ST_COMMIT     = 2'd2,
      ST_TX_RESP    = 2'd3
   } state_e;

   function automatic int ceil_bytes(input int bits);
      return (bits + 7) / 8;
   endfunction

endpackage

// File: rtl/mux_crossbar.sv
// Combinational crossbar: output k follows the input selected by map entry k;
// entries pointing past the last input yield 0.
module mux_crossbar #(
   parameter int N_OUT = 16,
   parameter int N_IN  = 4
) (
   input  logic [N_OUT*$clog2(N_IN)-1:0] map_i,
   input  logic [N_IN-1:0]               in_i,
   output logic [N_OUT-1:0]              data_o
);
   localparam int SEL_W = $clog2(N_IN);

   for (genvar k = 0; k < N_OUT; k++) begin : g_out
      logic [SEL_W-1:0] sel_s;
      assign sel_s     = map_i[k*SEL_W +: SEL_W];
      assign data_o[k] = (int'(sel_s) < N_IN) ? in_i[sel_s] : 1'b0;
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input sync, mid-bit sampling, one-cycle valid
// pulse only when the stop bit reads high.
module uart_rx #(
   parameter int CLK_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_i,
   output logic       valid_o,
   output logic [7:0] data_o
);
   localparam int CW = $clog2(CLK_PER_BIT) + 1;
   localparam logic [CW-1:0] FULL = CW'(CLK_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'(CLK_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;

   rx_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    sh_q, sh_d;
   logic          valid_q, valid_d;
   logic          meta_q, rx_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= R_IDLE;
         cnt_q   <= '0;
         bit_q   <= 3'd0;
         sh_q    <= 8'h00;
         valid_q <= 1'b0;
         meta_q  <= 1'b1;
         rx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         valid_q <= valid_d;
         meta_q  <= rx_i;
         rx_q    <= meta_q;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      valid_d = 1'b0;
      case (state_q)
         R_IDLE: begin
            cnt_d = '0;
            if (!rx_q) state_d = R_START;
            else       state_d = R_IDLE;
         end
         R_START: begin
            if (cnt_q == HALF) begin
               cnt_d = '0;
               bit_d = 3'd0;
               if (!rx_q) state_d = R_DATA;
               else       state_d = R_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         R_DATA: begin
            if (cnt_q == FULL) begin
               cnt_d = '0;
               sh_d  = {rx_q, sh_q[7:1]};
               if (bit_q == 3'd7) state_d = R_STOP;
               else               bit_d   = bit_q + 3'd1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         R_STOP: begin
            if (cnt_q == FULL) begin
               valid_d = rx_q;
               state_d = R_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = R_IDLE;
      endcase
   end

   assign valid_o = valid_q;
   assign data_o  = sh_q;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: accepts start_i when idle, pulses done_o as the stop
// bit ends and the line returns to idle.
module uart_tx #(
   parameter int CLK_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_i,
   input  logic [7:0] data_i,
   output logic       tx_o,
   output logic       done_o
);
   localparam int CW = $clog2(CLK_PER_BIT) + 1;
   localparam logic [CW-1:0] FULL = CW'(CLK_PER_BIT - 1);

   typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_e;

   tx_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    sh_q, sh_d;
   logic          tx_q, tx_d;
   logic          done_q, done_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= T_IDLE;
         cnt_q   <= '0;
         bit_q   <= 3'd0;
         sh_q    <= 8'h00;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      tx_d    = tx_q;
      done_d  = 1'b0;
      case (state_q)
         T_IDLE: begin
            cnt_d = '0;
            if (start_i) begin
               sh_d    = data_i;
               tx_d    = 1'b0;
               state_d = T_START;
            end else begin
               tx_d = 1'b1;
            end
         end
         T_START: begin
            if (cnt_q == FULL) begin
               cnt_d   = '0;
               bit_d   = 3'd0;
               tx_d    = sh_q[0];
               state_d = T_DATA;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         T_DATA: begin
            if (cnt_q == FULL) begin
               cnt_d = '0;
               if (bit_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = T_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
                  sh_d  = {1'b0, sh_q[7:1]};
                  tx_d  = sh_q[1];
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         T_STOP: begin
            if (cnt_q == FULL) begin
               done_d  = 1'b1;
               state_d = T_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = T_IDLE;
      endcase
   end

   assign tx_o   = tx_q;
   assign done_o = done_q;

endmodule

// File: rtl/mux_comm.sv
// UART-controlled tri-state pin crossbar: command/reply protocol over 8N1
// updating a MAP and MASK register that steer input_pins onto output_pins.
module mux_comm
   import mux_comm_pkg::*;
#(
   parameter int N_OUT        = 16,
   parameter int N_IN         = 4,
   parameter int CLK_PER_BIT  = 16,
   parameter int TIMEOUT_CLKS = 4096
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  serial_rx,
   output logic                  serial_tx,
   output wire logic [N_OUT-1:0] output_pins,
   input  logic [N_IN-1:0]       input_pins,
   output logic                  err_flag
);
   localparam int SEL_W = $clog2(N_IN);
   localparam int MAP_W = N_OUT * SEL_W;
   localparam int MB    = ceil_bytes(MAP_W);
   localparam int KB    = ceil_bytes(N_OUT);
   localparam int IB    = ceil_bytes(N_IN);
   localparam int BUF_B = (MB > IB) ? MB : IB;
   localparam int BUF_W = 8 * BUF_B;
   localparam int CNT_W = $clog2(BUF_B) + 1;
   localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1) + 1;

   localparam logic [CNT_W-1:0] MB_LAST = CNT_W'(MB - 1);
   localparam logic [CNT_W-1:0] KB_LAST = CNT_W'(KB - 1);
   localparam logic [CNT_W-1:0] IB_LAST = CNT_W'(IB - 1);
   localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CLKS);

   state_e           state_q, state_d;
   logic [MAP_W-1:0] map_q, map_d;
   logic [N_OUT-1:0] mask_q, mask_d;
   logic             err_q, err_d;
   logic [BUF_W-1:0] buf_q, buf_d;    // payload shadow, then reply bytes
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] last_q, last_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             wr_map_q, wr_map_d;
   logic             launch_q, launch_d;
   logic [N_IN-1:0]  in_meta_q, in_sync_q;

   logic             rx_valid_s;
   logic [7:0]       rx_data_s;
   logic             tx_start_s;
   logic [7:0]       tx_byte_s;
   logic             tx_done_s;
   logic [N_OUT-1:0] xbar_s;

   uart_rx #(.CLK_PER_BIT(CLK_PER_BIT)) u_rx (
      .clk     (clk),
      .rst_n   (rst_n),
      .rx_i    (serial_rx),
      .valid_o (rx_valid_s),
      .data_o  (rx_data_s)
   );

   uart_tx #(.CLK_PER_BIT(CLK_PER_BIT)) u_tx (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (tx_start_s),
      .data_i  (tx_byte_s),
      .tx_o    (serial_tx),
      .done_o  (tx_done_s)
   );

   mux_crossbar #(.N_OUT(N_OUT), .N_IN(N_IN)) u_xbar (
      .map_i  (map_q),
      .in_i   (input_pins),
      .data_o (xbar_s)
   );

   for (genvar k = 0; k < N_OUT; k++) begin : g_pin
      assign output_pins[k] = mask_q[k] ? xbar_s[k] : 1'bz;
   end

   assign err_flag = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         map_q     <= '0;
         mask_q    <= '0;
         err_q     <= 1'b0;
         buf_q     <= '0;
         cnt_q     <= '0;
         last_q    <= '0;
         tmo_q     <= '0;
         wr_map_q  <= 1'b0;
         launch_q  <= 1'b0;
         in_meta_q <= '0;
         in_sync_q <= '0;
      end else begin
         map_q     <= map_d;
         mask_q    <= mask_d;
         err_q     <= err_d;
         buf_q     <= buf_d;
         cnt_q     <= cnt_d;
         last_q    <= last_d;
         tmo_q     <= tmo_d;
         wr_map_q  <= wr_map_d;
         launch_q  <= launch_d;
         in_meta_q <= input_pins;
         in_sync_q <= in_meta_q;
      end
   end

   always_comb begin
      state_d  = state_q;
      map_d    = map_q;
      mask_d   = mask_q;
      err_d    = err_q;
      buf_d    = buf_q;
      cnt_d    = cnt_q;
      last_d   = last_q;
      tmo_d    = tmo_q;
      wr_map_d = wr_map_q;
      launch_d = launch_q;
      case (state_q)
         ST_IDLE: begin
            if (rx_valid_s) begin
               buf_d    = '0;
               cnt_d    = '0;
               tmo_d    = '0;
               last_d   = '0;
               launch_d = 1'b1;
               state_d  = ST_TX_RESP;
               case (rx_data_s[3:0])
                  OP_READ_MAP: begin
                     buf_d[MAP_W-1:0] = map_q;
                     last_d           = MB_LAST;
                  end
                  OP_WRITE_MAP: begin
                     wr_map_d = 1'b1;
                     last_d   = MB_LAST;
                     state_d  = ST_RX_PAYLOAD;
                  end
                  OP_READ_MASK: begin
                     buf_d[N_OUT-1:0] = mask_q;
                     last_d           = KB_LAST;
                  end
                  OP_WRITE_MASK: begin
                     wr_map_d = 1'b0;
                     last_d   = KB_LAST;
                     state_d  = ST_RX_PAYLOAD;
                  end
                  OP_READ_INPUTS: begin
                     buf_d[N_IN-1:0] = in_sync_q;
                     last_d          = IB_LAST;
                  end
                  OP_CLEAR_ERR: begin
                     err_d      = 1'b0;
                     buf_d[7:0] = REPLY_OK;
                  end
                  default: begin
                     err_d      = 1'b1;
                     buf_d[7:0] = REPLY_ERR;
                  end
               endcase
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RX_PAYLOAD: begin
            if (rx_valid_s) begin
               buf_d[int'(cnt_q)*8 +: 8] = rx_data_s;
               tmo_d = '0;
               if (cnt_q == last_q) state_d = ST_COMMIT;
               else                 cnt_d   = cnt_q + CNT_W'(1);
            end else if (tmo_q == TMO_MAX) begin
               // Abort: shadow dropped, live registers untouched.
               err_d      = 1'b1;
               buf_d      = '0;
               buf_d[7:0] = REPLY_ERR;
               cnt_d      = '0;
               last_d     = '0;
               launch_d   = 1'b1;
               state_d    = ST_TX_RESP;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         ST_COMMIT: begin
            buf_d    = '0;
            cnt_d    = '0;
            launch_d = 1'b1;
            state_d  = ST_TX_RESP;
            if (wr_map_q) begin
               map_d            = buf_q[MAP_W-1:0];
               buf_d[MAP_W-1:0] = buf_q[MAP_W-1:0];
            end else begin
               mask_d           = buf_q[N_OUT-1:0];
               buf_d[N_OUT-1:0] = buf_q[N_OUT-1:0];
            end
         end
         ST_TX_RESP: begin
            if (launch_q) begin
               launch_d = 1'b0;
            end else if (tx_done_s) begin
               if (cnt_q == last_q) begin
                  state_d = ST_IDLE;
               end else begin
                  cnt_d    = cnt_q + CNT_W'(1);
                  launch_d = 1'b1;
               end
            end else begin
               state_d = ST_TX_RESP;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      tx_byte_s = buf_q[int'(cnt_q)*8 +: 8];
      if ((state_q == ST_TX_RESP) && launch_q) tx_start_s = 1'b1;
      else                                     tx_start_s = 1'b0;
   end

endmodule

// File: tb/tb_mux_comm.sv
// Directed bench for mux_comm: a 16x4 instance and a 5x3 instance driven over
// their UART lines, with replies captured by per-instance line monitors.
module tb_mux_comm;
   localparam int CPB = 16;
   localparam int TMO = 4096;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_a  = 1'b1;
   logic       rx_b  = 1'b1;
   logic [3:0] in_a  = 4'h0;
   logic [2:0] in_b  = 3'h0;
   wire        tx_a, tx_b, err_a, err_b;
   wire [15:0] out_a;
   wire [4:0]  out_b;

   int n_total = 0;
   int n_bad   = 0;
   logic [7:0] rxq_a[$];
   logic [7:0] rxq_b[$];

   always #5 clk = ~clk;

   mux_comm #(.N_OUT(16), .N_IN(4), .CLK_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .serial_rx(rx_a), .serial_tx(tx_a),
      .output_pins(out_a), .input_pins(in_a), .err_flag(err_a)
   );

   mux_comm #(.N_OUT(5), .N_IN(3), .CLK_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .serial_rx(rx_b), .serial_tx(tx_b),
      .output_pins(out_b), .input_pins(in_b), .err_flag(err_b)
   );

   for (genvar g = 0; g < 2; g++) begin : g_mon
      initial begin
         logic [7:0] b;
         forever begin
            @(negedge clk);
            if (((g == 0) ? tx_a : tx_b) == 1'b0) begin
               repeat (CPB / 2) @(negedge clk);
               for (int i = 0; i < 8; i++) begin
                  repeat (CPB) @(negedge clk);
                  b[i] = (g == 0) ? tx_a : tx_b;
               end
               repeat (CPB) @(negedge clk);
               if (g == 0) rxq_a.push_back(b);
               else        rxq_b.push_back(b);
            end
         end
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input int p, input logic [7:0] b);
      logic [9:0] frame;
      frame = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         if (p == 0) rx_a = frame[i];
         else        rx_b = frame[i];
         repeat (CPB) @(negedge clk);
      end
   endtask

   task automatic exp_byte(input int p, input string tag, input logic [7:0] want);
      int waited;
      logic [31:0] got;
      waited = 0;
      while ((((p == 0) ? rxq_a.size() : rxq_b.size()) == 0) && (waited < 8000)) begin
         @(negedge clk);
         waited++;
      end
      if ((p == 0) && (rxq_a.size() > 0))      got = {24'h0, rxq_a.pop_front()};
      else if ((p == 1) && (rxq_b.size() > 0)) got = {24'h0, rxq_b.pop_front()};
      else                                     got = 32'hDEAD_BEEF;
      check_val(tag, got, {24'h0, want});
   endtask

   // cmd/rsp bytes are packed LSB-first: byte i sits at [8*i +: 8].
   task automatic txn(input int p, input logic [63:0] cmd, input int n_cmd,
                      input logic [31:0] rsp, input int n_rsp, input string tag);
      for (int i = 0; i < n_cmd; i++) send_byte(p, cmd[8*i +: 8]);
      for (int i = 0; i < n_rsp; i++) exp_byte(p, $sformatf("%s[%0d]", tag, i), rsp[8*i +: 8]);
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_val("rst_err_a", {31'd0, err_a}, 32'd0);
      check_val("rst_tx_a",  {31'd0, tx_a},  32'd1);
      check_val("rst_err_b", {31'd0, err_b}, 32'd0);

      txn(0, 64'h01, 1, 32'h0000_0000, 4, "rd_map_rst");
      txn(0, 64'h03, 1, 32'h0000_0000, 2, "rd_mask_rst");

      txn(0, 64'h89_AB_CD_EF_02, 5, 32'h89AB_CDEF, 4, "wr_map_echo");
      txn(0, 64'h01, 1, 32'h89AB_CDEF, 4, "rd_map_1");
      txn(0, 64'h01, 1, 32'h89AB_CDEF, 4, "rd_map_2");

      txn(0, 64'h00_00_00_00_02, 5, 32'h0000_0000, 4, "wr_map_zero");
      txn(0, 64'hFF_FF_04, 3, 32'h0000_FFFF, 2, "wr_mask_ff");
      in_a = 4'b0001;
      repeat (2) @(negedge clk);
      check_val("out_all_in0", {16'h0, out_a}, 32'h0000_FFFF);
      txn(0, 64'h00_00_00_01_02, 5, 32'h0000_0001, 4, "wr_map_e0");
      repeat (2) @(negedge clk);
      check_val("out_e0_in1", {16'h0, out_a}, 32'h0000_FFFE);
      in_a = 4'b0010;
      repeat (2) @(negedge clk);
      check_val("out_e0_swap", {16'h0, out_a}, 32'h0000_0001);

      in_a = 4'b1010;
      txn(0, 64'h05, 1, 32'h0000_000A, 1, "rd_inputs");

      txn(0, 64'h0F_04, 2, 32'h0000_00EE, 1, "tmo_reply");
      check_val("tmo_err", {31'd0, err_a}, 32'd1);
      txn(0, 64'h03, 1, 32'h0000_FFFF, 2, "tmo_mask_kept");
      txn(0, 64'hA6, 1, 32'h0000_0000, 1, "clr_err_hi_nib");
      check_val("clr_err", {31'd0, err_a}, 32'd0);

      txn(0, 64'h09, 1, 32'h0000_00EE, 1, "bad_op");
      check_val("bad_op_err", {31'd0, err_a}, 32'd1);
      txn(0, 64'h06, 1, 32'h0000_0000, 1, "clr_err_2");
      check_val("clr_err_2", {31'd0, err_a}, 32'd0);

      send_byte(0, 8'h02);
      send_byte(0, 8'hEF);
      send_byte(0, 8'hCD);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      txn(0, 64'h01, 1, 32'h0000_0000, 4, "rd_map_after_rst");
      txn(0, 64'h03, 1, 32'h0000_0000, 2, "rd_mask_after_rst");

      txn(1, 64'h03, 1, 32'h0000_0000, 1, "b_rd_mask_rst");
      txn(1, 64'h1F_04, 2, 32'h0000_001F, 1, "b_wr_mask");
      txn(1, 64'hFF_FF_02, 3, 32'h0000_03FF, 2, "b_wr_map_ff");
      in_b = 3'b111;
      repeat (2) @(negedge clk);
      check_val("b_out_sel3", {27'h0, out_b}, 32'h0000_0000);
      txn(1, 64'h00_24_02, 3, 32'h0000_0024, 2, "b_wr_map_24");
      in_b = 3'b110;
      repeat (2) @(negedge clk);
      check_val("b_out_map24", {27'h0, out_b}, 32'h0000_0006);
      txn(1, 64'h05, 1, 32'h0000_0006, 1, "b_rd_inputs");
      txn(1, 64'h01, 1, 32'h0000_0024, 2, "b_rd_map");

      repeat (4 * CPB) @(negedge clk);
      check_val("no_extra_a", rxq_a.size(), 32'd0);
      check_val("no_extra_b", rxq_b.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/mux_comm.md
MUX_COMM -- requirements
Module: mux_comm

Interface
REQ-001 SHALL have parameter N_OUT, default 16, number of tri-state output pins (1..64).
REQ-002 SHALL have parameter N_IN, default 4, number of input pins (2..16); SEL_W = clog2(N_IN).
REQ-003 SHALL have parameter CLK_PER_BIT, default 16, UART bit period in clk cycles.
REQ-004 SHALL have parameter TIMEOUT_CLKS, default 4096, maximum inter-byte gap during payload reception.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 serial_rx  input  1  UART receive line, 8N1, idle high.
REQ-008 serial_tx  output  1  UART transmit line, 8N1, idle high.
REQ-009 output_pins  output  N_OUT  muxed outputs; bit k is Z when mask[k]=0.
REQ-010 input_pins  input  N_IN  mux sources.
REQ-011 err_flag  output  1  sticky: set on timeout or bad opcode; cleared by CLEAR_ERR or reset.

Function
REQ-012 SHALL hold map register MAP (N_OUT*SEL_W bits, entry k at [k*SEL_W+:SEL_W]) and MASK register (N_OUT bits).
REQ-013 output_pins[k] SHALL equal input_pins[MAP entry k] when MASK[k]=1, or 0 if entry >= N_IN; combinational, no added latency.
REQ-014 MB = ceil(N_OUT*SEL_W/8) map bytes; KB = ceil(N_OUT/8) mask bytes; multi-byte values sent/received LSB byte first.
REQ-015 Opcodes (command byte[3:0]; byte[7:4] ignored): 0x1 READ_MAP, 0x2 WRITE_MAP, 0x3 READ_MASK, 0x4 WRITE_MASK, 0x5 READ_INPUTS, 0x6 CLEAR_ERR.
REQ-016 READ_MAP/READ_MASK SHALL reply MB/KB bytes of the current register.
REQ-017 WRITE_MAP/WRITE_MASK SHALL receive MB/KB payload bytes into a shadow register, commit atomically one cycle after the last byte, then echo the committed value (MB/KB bytes).
REQ-018 Bits above N_OUT*SEL_W (map) or N_OUT (mask) in payload SHALL be discarded and echoed as 0.
REQ-019 READ_INPUTS SHALL reply ceil(N_IN/8) bytes of input_pins, two-flop synchronised, sampled when the command byte is accepted.
REQ-020 CLEAR_ERR SHALL clear err_flag and reply one byte 0x00.
REQ-021 Unknown opcode SHALL set err_flag and reply one byte 0xEE.
REQ-022 FSM states IDLE -> RX_PAYLOAD (write opcodes) -> COMMIT -> TX_RESP -> IDLE; read/other opcodes IDLE -> TX_RESP -> IDLE.
REQ-023 TX_RESP SHALL launch each reply byte only after previous tx_done; the next command byte SHALL NOT be accepted until the reply completes.
REQ-024 Bytes received while in TX_RESP SHALL be dropped.
REQ-025 In RX_PAYLOAD, a gap > TIMEOUT_CLKS cycles since the last byte SHALL abort: shadow discarded, live register unchanged, err_flag set, reply 0xEE, return to IDLE.
REQ-026 Byte counter SHALL be 0-based and reset on every new command; no wrap beyond MB-1.

Reset
REQ-027 On rst_n low: MAP=0, MASK=0 (all outputs Z), err_flag=0, serial_tx=1, FSM=IDLE, counters and shadow cleared.
REQ-028 Reset mid-command SHALL abort without commit; the first byte after release is treated as a command.

Structure
REQ-029 Opcode constants and state encodings SHALL live in shared package mux_comm_pkg.
REQ-030 The crossbar SHALL be sub-module mux_crossbar (parameters N_OUT, N_IN); existing uart_rx/uart_tx SHALL be instantiated with CLK_PER_BIT.

Verification
REQ-031 Reset, READ_MAP then READ_MASK -> 4 bytes 00, then 2 bytes 00; all outputs Z.
REQ-032 WRITE_MAP payload EF CD AB 89 -> echo EF CD AB 89; READ_MAP twice -> same 4 bytes.
REQ-033 MAP=0, WRITE_MASK FF FF, input_pins=4'b0001 -> all outputs 1; WRITE_MAP 01 00 00 00 -> output 0 = 0, outputs 1..15 = 1.
REQ-034 WRITE_MASK with one payload byte then TIMEOUT_CLKS+1 idle -> reply EE, err_flag=1, MASK unchanged; CLEAR_ERR -> reply 00, err_flag=0.
REQ-035 N_OUT=5, N_IN=3 build: WRITE_MAP FF FF -> echo FF 03, outputs with entry 3 driven 0.
REQ-036 Opcode 0x9 -> reply EE, err_flag=1; rst_n pulse during WRITE_MAP payload -> MAP reads back 0.
